// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared ROM controller/prefetcher types and default widths
package rom_pkg;
   localparam int ROM_WIDTH  = 16;
   localparam int ROM_ADDR_W = 24;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT} fetch_state_t;
endpackage

// File: rtl/rom_prefetch_if.sv
// rtl/rom_prefetch_if.sv - CPU fetch and ROM controller signals of the prefetcher
interface rom_prefetch_if import rom_pkg::*; #(
   parameter int WIDTH    = ROM_WIDTH,
   parameter int ROM_ADDR = ROM_ADDR_W
);
   logic [ROM_ADDR-1:0] cpu_addr;
   logic                cpu_req;
   logic [WIDTH-1:0]    cpu_data;
   logic                cpu_valid;
   logic [ROM_ADDR-1:0] rom_addr;
   logic                rom_load;
   logic [WIDTH-1:0]    rom_data;
   logic                rom_ready;

   modport master (
      input  cpu_addr, cpu_req, rom_data, rom_ready,
      output cpu_data, cpu_valid, rom_addr, rom_load
   );

   modport slave (
      output cpu_addr, cpu_req, rom_data, rom_ready,
      input  cpu_data, cpu_valid, rom_addr, rom_load
   );
endinterface

// File: rtl/rom_prefetch_fifo.sv
// rtl/rom_prefetch_fifo.sv - {addr, data} FIFO with synchronous clear and registered head
module rom_prefetch_fifo #(
   parameter int AW    = 24,
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [AW-1:0]            push_addr,
   input  logic [DW-1:0]            push_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic [AW-1:0]            head_addr,
   output logic [DW-1:0]            head_data
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] head, tail;
   logic          do_push, do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem[i] <= '0;
            data_mem[i] <= '0;
         end
      end else if (clr) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
            tail           <= tail + PW'(1);
         end
         if (do_pop) begin
            head <= head + PW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + (PW+1)'(1);
         end else if (do_pop && !do_push) begin
            count <= count - (PW+1)'(1);
         end
      end
   end

   assign head_addr = addr_mem[head];
   assign head_data = data_mem[head];
endmodule

// File: rtl/rom_prefetch.sv
// rtl/rom_prefetch.sv - sequential ROM instruction prefetcher; ROM_PREFETCH_EN enables speculative prefetch
module rom_prefetch import rom_pkg::*; #(
   parameter int WIDTH    = ROM_WIDTH,
   parameter int ROM_ADDR = ROM_ADDR_W,
   parameter int DEPTH    = 4
) (
   input logic            clk,
   input logic            rst,
   rom_prefetch_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_state_t        state;
   logic [ROM_ADDR-1:0] fetch_addr;
   logic [ROM_ADDR-1:0] exp_addr;
   logic [ROM_ADDR-1:0] head_addr;
   logic [WIDTH-1:0]    head_data;
   logic [CW-1:0]       count;
   logic [CW-1:0]       count_after;
   logic                hit;
   logic                redirect;
   logic                push;
   logic                permit;

   assign exp_addr    = (count != '0) ? head_addr : fetch_addr;
   assign hit         = bus.cpu_req && (count != '0) && (head_addr == bus.cpu_addr);
   assign redirect    = bus.cpu_req && (bus.cpu_addr != exp_addr);
   assign push        = (state == WAIT) && bus.rom_ready && !redirect;
   assign count_after = count + CW'(push) - CW'(hit);

`ifdef ROM_PREFETCH_EN
   assign permit = 1'b1;
`else
   assign permit = bus.cpu_req && (count == '0) && (state == IDLE) && (bus.cpu_addr == fetch_addr);
`endif

   assign bus.cpu_valid = hit;
   assign bus.cpu_data  = hit ? head_data : '0;

   rom_prefetch_fifo #(
      .AW    (ROM_ADDR),
      .DW    (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (redirect),
      .push      (push),
      .pop       (hit),
      .push_addr (fetch_addr),
      .push_data (bus.rom_data),
      .count     (count),
      .head_addr (head_addr),
      .head_data (head_data)
   );

   // A redirect overrides every state, so an in-flight word is simply never pushed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         fetch_addr   <= '0;
         bus.rom_load <= 1'b0;
         bus.rom_addr <= '0;
      end else if (redirect) begin
         state        <= LOAD;
         fetch_addr   <= bus.cpu_addr;
         bus.rom_load <= 1'b1;
         bus.rom_addr <= bus.cpu_addr;
      end else begin
         case (state)
            IDLE: begin
               if (permit && (count < FULL)) begin
                  state        <= LOAD;
                  bus.rom_load <= 1'b1;
                  bus.rom_addr <= fetch_addr;
               end
            end
            LOAD: begin
               state        <= WAIT;
               bus.rom_load <= 1'b0;
            end
            WAIT: begin
               if (bus.rom_ready) begin
                  fetch_addr <= fetch_addr + ROM_ADDR'(1);
                  if (permit && (count_after < FULL)) begin
                     state        <= LOAD;
                     bus.rom_load <= 1'b1;
                     bus.rom_addr <= fetch_addr + ROM_ADDR'(1);
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state        <= IDLE;
               bus.rom_load <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/rom_prefetch.md
# rom_prefetch

Sequential instruction prefetcher between the CPU fetch stage and the StrataFlash ROM controller. It accepts word-address fetch requests from the CPU and issues single-word `load` requests to the controller. Returned words go into a small FIFO tagged with their address, and the FIFO is flushed when the CPU's address leaves the sequential stream. Consecutive addresses mostly fall in the same ROM page, so streaming ahead turns page-hit latency into near-continuous instruction supply.

## Interface
- `WIDTH`, 16: ROM data word width.
- `ROM_ADDR`, 24: ROM address width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `cpu_addr`  in  ROM_ADDR  requested word address.
- `cpu_req`  in  1  fetch request; the CPU holds `cpu_req` and `cpu_addr` stable until `cpu_valid`.
- `cpu_data`  out  WIDTH  FIFO head data.
- `cpu_valid`  out  1  `cpu_data` is the word at `cpu_addr`; the entry is consumed in this cycle.
- `rom_addr`  out  ROM_ADDR  address to the controller; registered.
- `rom_load`  out  1  one-cycle load strobe to the controller.
- `rom_data`  in  WIDTH  controller data.
- `rom_ready`  in  1  controller ready.

## Operation
- **Storage:** FIFO of `{addr, data}` pairs, with head/tail pointers and `count` (0..DEPTH).
- **`fetch_addr` register:** address of the in-flight or next fetch.
- **Expected address:** `exp = (count>0) ? head.addr : fetch_addr`.
- **Hit:** `cpu_req && count>0 && head.addr==cpu_addr`.
  - `cpu_valid=1` and `cpu_data=head.data`, combinationally.
  - The head is popped at the clock edge.
- **Redirect:** `cpu_req && cpu_addr!=exp`.
  - The FIFO is cleared (`count<=0`) and `fetch_addr<=cpu_addr`.
  - Any in-flight result is discarded.
  - The FSM goes to LOAD.
  - `cpu_valid=0` in that cycle.
- **FSM states:** IDLE, LOAD, WAIT.
  - **IDLE:** go to LOAD when a fetch is permitted (see Configuration) and `count<DEPTH`.
  - **LOAD:** `rom_load=1` and `rom_addr=fetch_addr`; always go to WAIT. `rom_ready` is ignored in LOAD because its value is stale.
  - **WAIT:** on `rom_ready`, push `{fetch_addr, rom_data}` and set `fetch_addr<=fetch_addr+1`.
    - If a fetch is still permitted and post-push `count<DEPTH`, go to LOAD; otherwise go to IDLE.
- **Simultaneous events:**
  - Pop and push in the same cycle: `count` is unchanged.
  - Redirect and push in the same cycle: the redirect wins and the push is dropped.
  - Redirect during LOAD: the current strobe completes, and the next cycle strobes LOAD again with the new address.
- **Full:** no LOAD is issued while `count==DEPTH`. At most one read is ever in flight, so a push can never overflow.
- **Wrap-around:** `fetch_addr` wraps from 2^ROM_ADDR−1 to 0, modulo arithmetic, with no special case.

## Timing
- **Reset values:**
  - IDLE, `count=0`, `fetch_addr=0`, storage cleared.
  - Outputs: `rom_load=0`, `rom_addr=0`, `cpu_valid=0`, `cpu_data=0`.
  - Reset mid-operation aborts any read; the controller's late ready is ignored because the FSM is in IDLE.
- **Miss latency with the controller at P_MISS=4, P_HIT=2:**
  - Redirect in cycle 0, LOAD in cycle 1.
  - Ready in cycle 5 for a page miss, or cycle 3 for a page hit.
  - `cpu_valid` rises one cycle after the push.
- **Streaming throughput:** one word per 3 cycles on page hits (LOAD, WAIT, WAIT+ready).
- **Hit latency:** zero cycles; `cpu_valid` is combinational from the registered head.

## Configuration
- **With `ROM_PREFETCH_EN` defined:** a fetch is permitted whenever `count<DEPTH`. This is speculative sequential prefetch, including immediately after reset, starting at address 0.
- **Without it:** a fetch is permitted only when `cpu_req && count==0 && state==IDLE && cpu_addr==fetch_addr`. Redirect still sets `fetch_addr`. The block then behaves as a demand-only single-word fetcher, and `DEPTH` is effectively 1.

## Structure
- Shared package `rom_pkg`:
  - FSM state type `fetch_state_t` (IDLE, LOAD, WAIT).
  - Default `ROM_WIDTH`/`ROM_ADDR_W` constants, also used by the ROM controller.
- Sub-module `rom_prefetch_fifo`: parameterised `{addr, data}` FIFO with push, pop, synchronous clear, `count` and head outputs.

## Test plan
- **Reset then streaming:** reset, model controller (P_MISS=4, P_HIT=2), `cpu_req` with `cpu_addr=0` → `rom_load` with `rom_addr=0` in cycle 1. Word 0 valid by cycle 6, then addresses 1,2,3 fill the FIFO and `rom_load` stops at `count==4`.
- **Sequential consume:** CPU requests 0..7 back-to-back → every word is returned in order with the correct data. After the FIFO drains, steady state is one `cpu_valid` every 3 cycles.
- **Branch:** with the FIFO holding 4..7, request `0x000100` → `cpu_valid=0`, FIFO cleared, `rom_addr=0x000100` strobed next cycle, and data valid after miss latency.
- **Redirect while WAIT:** redirect arrives in the same cycle as `rom_ready` → the stale word is not pushed and the new address is loaded.
- **Wrap-around:** `fetch_addr=0xFFFFFF` → next fetch is `0x000000`.
- **Macro off:** no `rom_load` while `cpu_req=0`, and exactly one load per requested word.
